pipeline_elastic_stage: RTL

PIPELINE_ELASTIC_STAGE -- requirements
Module: pipeline_elastic_stage

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/pipe_slot.sv | 47 ++++
 rtl/pipeline_elastic_stage.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage.
// Holds the occupancy width, slot-state encodings and flush-policy values.
package pipe_pkg;

  localparam int OCC_W = 2;

  localparam bit FLUSH_CLEAR = 1'b1;
  localparam bit FLUSH_KEEP  = 1'b0;

  // Encoding doubles as the entry count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  function automatic state_t state_of(
    input logic main_v,
    input logic skid_v
  );
    if (main_v && skid_v) return ST_FULL;
    if (main_v) return ST_ONE;
    return ST_EMPTY;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot: valid bit plus payload register.
// Ports: clk, rst_n (async low), load_i, clear_i (wins over load),
//        data_i, valid_o, data_o. CLEAR_PAYLOAD zeroes data on clear.
import pipe_pkg::*;

module pipe_slot #(
  parameter int DATA_WIDTH    = 32,
  parameter bit CLEAR_PAYLOAD = FLUSH_CLEAR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      if (CLEAR_PAYLOAD) data_d = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipeline_elastic_stage.sv
// Elastic valid/ready pipeline stage with optional skid slot.
// Ports: clk, rst_n (async low), flush, in_valid/in_ready/in_data,
//        out_valid/out_ready/out_data, occupancy (0..2).
// Macro PIPE_STAGE_SKID_EN adds the skid slot and registers in_ready;
// without it in_ready is combinational and occupancy is at most 1.
import pipe_pkg::*;

module pipeline_elastic_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter bit CLEAR_ON_FLUSH = FLUSH_CLEAR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [OCC_W-1:0]      occupancy
);

  logic                  accept;
  logic                  fire;
  logic                  main_load;
  logic                  main_clr;
  logic                  main_v;
  logic [DATA_WIDTH-1:0] main_din;
  logic [DATA_WIDTH-1:0] main_q;
  state_t                st;

  assign accept = in_valid & in_ready;
  assign fire   = out_valid & out_ready;

  pipe_slot #(
    .DATA_WIDTH   (DATA_WIDTH),
    .CLEAR_PAYLOAD(CLEAR_ON_FLUSH)
  ) u_main (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (main_load),
    .clear_i(main_clr),
    .data_i (main_din),
    .valid_o(main_v),
    .data_o (main_q)
  );

  assign out_valid = main_v;
  assign out_data  = main_q;

`ifdef PIPE_STAGE_SKID_EN
  logic                  skid_load;
  logic                  skid_clr;
  logic                  skid_v;
  logic [DATA_WIDTH-1:0] skid_q;

  pipe_slot #(
    .DATA_WIDTH   (DATA_WIDTH),
    .CLEAR_PAYLOAD(CLEAR_ON_FLUSH)
  ) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (skid_load),
    .clear_i(skid_clr),
    .data_i (in_data),
    .valid_o(skid_v),
    .data_o (skid_q)
  );

  assign st = state_of(main_v, skid_v);

  // Straight from the skid valid flop: no path from out_ready.
  assign in_ready = ~skid_v;

  always_comb begin
    main_load = 1'b0;
    main_clr  = 1'b0;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    main_din  = in_data;
    if (flush) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (st)
        ST_EMPTY: main_load = accept;
        ST_ONE: begin
          main_load = accept & fire;
          skid_load = accept & ~fire;
          main_clr  = fire & ~accept;
        end
        ST_FULL: begin
          if (fire) begin
            main_load = 1'b1;
            main_din  = skid_q;
            skid_clr  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign st = state_of(main_v, 1'b0);

  assign in_ready = ~main_v | out_ready;

  always_comb begin
    main_load = 1'b0;
    main_clr  = 1'b0;
    main_din  = in_data;
    if (flush) main_clr = 1'b1;
    else if (accept) main_load = 1'b1;
    else if (fire) main_clr = 1'b1;
  end
`endif

  assign occupancy = OCC_W'(st);

endmodule
